rps_round_ctrl: RTL and testbench

- Round/match sequencer between the SPI byte receiver and the LED output stage.
- Collects one move per player from received SPI bytes in either order, judges the round, and holds the result on the LEDs for a fixed time.
- Keeps per-player scores and declares the match over at a target score.
- Runs on the SPI-side clock domain.

---
 rtl/rps_round_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_rps_round_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rps_round_ctrl.sv
// rtl/rps_round_ctrl.sv - rock-paper-scissors round and match sequencer on the sck domain
// Optional ROUND_TIMEOUT_EN: a lone move wins by forfeit after TIMEOUT_CYCLES in COLLECT.
module rps_round_ctrl #(
  parameter int SHOW_CYCLES    = 1024,
  parameter int WIN_TARGET     = 3,
  parameter int SCORE_W        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               sck,
  input  logic               reset,
  input  logic [7:0]         SIG,
  input  logic               done,
  output logic               start,
  output logic [2:0]         LED,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               match_over,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_JUDGE   = 2'd2;
  localparam logic [1:0] ST_SHOW    = 2'd3;

  localparam logic [1:0] MV_NONE     = 2'b00;
  localparam logic [1:0] MV_ROCK     = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_P1  = 3'b001;
  localparam logic [2:0] LED_P2  = 3'b010;
  localparam logic [2:0] LED_TIE = 3'b100;

  localparam int                 SHOW_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SHOW_W-1:0]  SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic               done_q, done_d;
  logic               start_q, start_d;
  logic [2:0]         led_q, led_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  logic               match_over_q, match_over_d;
  logic [1:0]         m1_q, m1_d;
  logic [1:0]         m2_q, m2_d;
  logic [SHOW_W-1:0]  show_cnt_q, show_cnt_d;

  logic               byte_ok, new_match, mv_p1, mv_p2;
  logic               tie, p1_beats;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

`ifdef ROUND_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // A byte counts only on the first cycle done is seen high after being low.
  always_comb begin
    byte_ok   = done && !done_q;
    new_match = byte_ok && (SIG == 8'hFF);
    mv_p1     = byte_ok && (SIG[7:6] == 2'b01) && (SIG[1:0] != MV_NONE);
    mv_p2     = byte_ok && (SIG[7:6] == 2'b10) && (SIG[1:0] != MV_NONE);
  end

  always_comb begin
    tie      = (m1_q == m2_q);
    p1_beats = ((m1_q == MV_ROCK)     && (m2_q == MV_SCISSORS)) ||
               ((m1_q == MV_SCISSORS) && (m2_q == MV_PAPER))    ||
               ((m1_q == MV_PAPER)    && (m2_q == MV_ROCK));
    p1_inc   = (score_p1_q == SCORE_MAX) ? score_p1_q : score_p1_q + SCORE_W'(1);
    p2_inc   = (score_p2_q == SCORE_MAX) ? score_p2_q : score_p2_q + SCORE_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done;
    start_d      = 1'b0;
    led_d        = led_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    match_over_d = match_over_q;
    m1_d         = m1_q;
    m2_d         = m2_q;
    show_cnt_d   = show_cnt_q;
`ifdef ROUND_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        led_d = LED_OFF;
        if ((mv_p1 || mv_p2) && !match_over_q) begin
          state_d = ST_COLLECT;
          start_d = 1'b1;
          if (mv_p1) m1_d = SIG[1:0];
          else       m2_d = SIG[1:0];
`ifdef ROUND_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end

      ST_COLLECT: begin
        if (mv_p1 && (m1_q == MV_NONE)) m1_d = SIG[1:0];
        if (mv_p2 && (m2_q == MV_NONE)) m2_d = SIG[1:0];
        if ((m1_d != MV_NONE) && (m2_d != MV_NONE)) begin
          state_d = ST_JUDGE;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Only one move can be stored here, so its owner takes the round.
          state_d    = ST_SHOW;
          show_cnt_d = SHOW_LOAD;
          if (m1_d != MV_NONE) begin
            led_d      = LED_P1;
            score_p1_d = p1_inc;
            if (p1_inc == TARGET) match_over_d = 1'b1;
          end else begin
            led_d      = LED_P2;
            score_p2_d = p2_inc;
            if (p2_inc == TARGET) match_over_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      ST_JUDGE: begin
        state_d    = ST_SHOW;
        show_cnt_d = SHOW_LOAD;
        if (tie) begin
          led_d = LED_TIE;
        end else if (p1_beats) begin
          led_d      = LED_P1;
          score_p1_d = p1_inc;
          if (p1_inc == TARGET) match_over_d = 1'b1;
        end else begin
          led_d      = LED_P2;
          score_p2_d = p2_inc;
          if (p2_inc == TARGET) match_over_d = 1'b1;
        end
      end

      default: begin
        if (show_cnt_q == '0) begin
          state_d = ST_IDLE;
          led_d   = LED_OFF;
          m1_d    = MV_NONE;
          m2_d    = MV_NONE;
        end else begin
          show_cnt_d = show_cnt_q - SHOW_W'(1);
        end
      end
    endcase

    // NEW_MATCH overrides whatever the state machine decided this cycle.
    if (new_match) begin
      state_d      = ST_IDLE;
      start_d      = 1'b0;
      led_d        = LED_OFF;
      score_p1_d   = '0;
      score_p2_d   = '0;
      match_over_d = 1'b0;
      m1_d         = MV_NONE;
      m2_d         = MV_NONE;
    end
  end

  always_ff @(posedge sck) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      start_q      <= 1'b0;
      led_q        <= LED_OFF;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      match_over_q <= 1'b0;
      m1_q         <= MV_NONE;
      m2_q         <= MV_NONE;
      show_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      start_q      <= start_d;
      led_q        <= led_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      match_over_q <= match_over_d;
      m1_q         <= m1_d;
      m2_q         <= m2_d;
      show_cnt_q   <= show_cnt_d;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  always_ff @(posedge sck) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`endif

  assign start      = start_q;
  assign LED        = led_q;
  assign score_p1   = score_p1_q;
  assign score_p2   = score_p2_q;
  assign match_over = match_over_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb/tb_rps_round_ctrl.sv - directed table-driven bench for rps_round_ctrl
module tb_rps_round_ctrl;
  localparam int SHOW_CYCLES = 16;

  logic       sck;
  logic       reset;
  logic [7:0] SIG;
  logic       done;
  logic       start;
  logic [2:0] LED;
  logic [3:0] score_p1, score_p2;
  logic       match_over;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  rps_round_ctrl #(
    .SHOW_CYCLES(SHOW_CYCLES),
    .WIN_TARGET(3),
    .SCORE_W(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .sck(sck),
    .reset(reset),
    .SIG(SIG),
    .done(done),
    .start(start),
    .LED(LED),
    .score_p1(score_p1),
    .score_p2(score_p2),
    .match_over(match_over),
    .busy(busy)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  // bytes[7:0] is sent first
  typedef struct packed {
    logic [23:0] bytes;
    logic [1:0]  n;
    logic [2:0]  led;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        mo;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(negedge sck);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [7:0] b);
    SIG  = b;
    done = 1'b1;
    tick();
  endtask

  task automatic release_done();
    done = 1'b0;
    tick();
  endtask

  task automatic send(input logic [7:0] b);
    press(b);
    release_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{24'h42_81_82, 2'd3, 3'b100, 4'd1, 4'd0, 1'b0};
    vecs[1] = '{24'h00_4F_81, 2'd2, 3'b010, 4'd1, 4'd1, 1'b0};
    vecs[2] = '{24'h00_81_42, 2'd2, 3'b001, 4'd2, 4'd1, 1'b0};
    vecs[3] = '{24'h00_83_42, 2'd2, 3'b010, 4'd2, 4'd2, 1'b0};
    vecs[4] = '{24'h00_82_41, 2'd2, 3'b010, 4'd2, 4'd3, 1'b1};

    reset = 1'b1;
    SIG   = 8'h00;
    done  = 1'b0;
    tick();
    tick();
    check("rst_led", int'(LED), 0);
    check("rst_s1", int'(score_p1), 0);
    check("rst_s2", int'(score_p2), 0);
    check("rst_mo", int'(match_over), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(start), 0);
    reset = 1'b0;
    tick();

    // First round by hand: start pulse and judge latency
    press(8'h41);
    check("r_start_pulse", int'(start), 1);
    check("r_busy", int'(busy), 1);
    release_done();
    check("r_start_once", int'(start), 0);
    SIG  = 8'h83;
    done = 1'b1;
    tick();
    check("r_led_judge_cycle", int'(LED), 0);
    done = 1'b0;
    tick();
    check("r_led_p1", int'(LED), 1);
    check("r_s1", int'(score_p1), 1);
    check("r_s2", int'(score_p2), 0);
    repeat (SHOW_CYCLES - 1) tick();
    check("r_led_held", int'(LED), 1);
    tick();
    check("r_led_off", int'(LED), 0);
    check("r_busy_off", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++) send(vecs[i].bytes[8*j +: 8]);
      check($sformatf("v%0d_led", i), int'(LED), int'(vecs[i].led));
      check($sformatf("v%0d_s1", i), int'(score_p1), int'(vecs[i].s1));
      check($sformatf("v%0d_s2", i), int'(score_p2), int'(vecs[i].s2));
      check($sformatf("v%0d_mo", i), int'(match_over), int'(vecs[i].mo));
      repeat (SHOW_CYCLES - 1) tick();
      check($sformatf("v%0d_led_held", i), int'(LED), int'(vecs[i].led));
      tick();
      check($sformatf("v%0d_led_off", i), int'(LED), 0);
      check($sformatf("v%0d_idle", i), int'(busy), 0);
    end

    // Match over: moves ignored until NEW_MATCH
    press(8'h41);
    check("mo_no_start", int'(start), 0);
    check("mo_no_busy", int'(busy), 0);
    release_done();
    send(8'hFF);
    check("nm_s1", int'(score_p1), 0);
    check("nm_s2", int'(score_p2), 0);
    check("nm_mo", int'(match_over), 0);

    // done held high: only the rising edge is taken, even if SIG changes
    press(8'h41);
    check("hold_busy", int'(busy), 1);
    repeat (4) tick();
    SIG = 8'h83;
    repeat (5) tick();
    check("hold_no_judge", int'(LED), 0);
    release_done();
    send(8'h82);
    check("hold_led_p2", int'(LED), 2);
    check("hold_s1", int'(score_p1), 0);
    check("hold_s2", int'(score_p2), 1);
    repeat (SHOW_CYCLES) tick();
    check("hold_idle", int'(busy), 0);

    // Invalid bytes in IDLE and COLLECT
    send(8'h00);
    send(8'hC1);
    send(8'h40);
    check("inv_idle_busy", int'(busy), 0);
    send(8'h41);
    send(8'h00);
    send(8'hC1);
    send(8'h80);
    check("inv_collect_led", int'(LED), 0);
    check("inv_collect_busy", int'(busy), 1);
    repeat (100) tick();
    check("collect_waits", int'(busy), 1);
    send(8'h83);
    check("late_led_p1", int'(LED), 1);
    check("late_s1", int'(score_p1), 1);
    check("late_s2", int'(score_p2), 1);

    // Reset mid-SHOW
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mrst_led", int'(LED), 0);
    check("mrst_s1", int'(score_p1), 0);
    check("mrst_s2", int'(score_p2), 0);
    check("mrst_mo", int'(match_over), 0);
    check("mrst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();

    // NEW_MATCH while collecting
    send(8'h42);
    check("nmc_busy", int'(busy), 1);
    send(8'hFF);
    check("nmc_idle", int'(busy), 0);
    send(8'h81);
    send(8'h43);
    check("nmc_fresh_led", int'(LED), 2);
    check("nmc_fresh_s2", int'(score_p2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
